// File: rtl/alarm_ctrl_if.sv
// Signal bundle between the time/setter/button sources and the alarm controller.
// The master drives time, alarm, switch and buttons; the slave returns the alarm outputs.
interface alarm_ctrl_if;
  logic       tick_1hz;
  logic [3:0] ch1, ch0, cm1, cm0, cs1, cs0;
  logic [3:0] ah1, ah0, am1, am0;
  logic       alarm_en;
  logic       push_stop;
  logic       push_snooze;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [3:0] snooze_cnt;

  modport master (
    output tick_1hz, ch1, ch0, cm1, cm0, cs1, cs0, ah1, ah0, am1, am0,
           alarm_en, push_stop, push_snooze,
    input  buzzer, ringing, snoozing, snooze_cnt
  );

  modport slave (
    input  tick_1hz, ch1, ch0, cm1, cm0, cs1, cs0, ah1, ah0, am1, am0,
           alarm_en, push_stop, push_snooze,
    output buzzer, ringing, snoozing, snooze_cnt
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller: compares alarm time to the running clock, rings the buzzer,
// and handles stop/snooze buttons plus ring and snooze timeouts on a 1 Hz tick.
module alarm_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic         clk,
  input  logic         reset,
  alarm_ctrl_if.slave  bus
);

  localparam logic [8:0] RING_LOAD = 9'(RING_SECS);
  localparam logic [8:0] SNZ_LOAD  = 9'(SNOOZE_SECS);
  localparam logic [3:0] SNZ_MAX   = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  // Index 0 = stop, index 1 = snooze; both buttons are active-low.
  logic [1:0] btn_raw;
  logic [1:0] btn_evt;

  assign btn_raw = {bus.push_snooze, bus.push_stop};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic sync1_q, sync2_q, hist_q, evt_q;
      logic sync1_d, sync2_d, hist_d, evt_d;

      // The event is registered so the FSM never sees a combinational button path.
      always_comb begin
        sync1_d = btn_raw[gi];
        sync2_d = sync1_q;
        hist_d  = sync2_q;
        evt_d   = hist_q & ~sync2_q;
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q <= 1'b1;
          sync2_q <= 1'b1;
          hist_q  <= 1'b1;
          evt_q   <= 1'b0;
        end else begin
          sync1_q <= sync1_d;
          sync2_q <= sync2_d;
          hist_q  <= hist_d;
          evt_q   <= evt_d;
        end
      end

      assign btn_evt[gi] = evt_q;
    end
  endgenerate

  logic stop_evt, snooze_evt, match;

  assign stop_evt   = btn_evt[0];
  assign snooze_evt = btn_evt[1];
  assign match = bus.tick_1hz
               && ({bus.ch1, bus.ch0, bus.cm1, bus.cm0} == {bus.ah1, bus.ah0, bus.am1, bus.am0})
               && ({bus.cs1, bus.cs0} == 8'h00);

  state_t     state_q, state_d;
  logic [8:0] ring_cnt_q, ring_cnt_d;
  logic [8:0] snz_cnt_q, snz_cnt_d;
  logic       buzzer_q, buzzer_d;
  logic [3:0] snooze_cnt_q, snooze_cnt_d;

  always_comb begin
    state_d      = state_q;
    ring_cnt_d   = ring_cnt_q;
    snz_cnt_d    = snz_cnt_q;
    buzzer_d     = buzzer_q;
    snooze_cnt_d = snooze_cnt_q;

    if (!bus.alarm_en) begin
      state_d  = IDLE;
      buzzer_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match) begin
            state_d      = RINGING;
            ring_cnt_d   = RING_LOAD;
            buzzer_d     = 1'b1;
            snooze_cnt_d = 4'd0;
          end
        end

        RINGING: begin
          if (stop_evt) begin
            state_d  = IDLE;
            buzzer_d = 1'b0;
          end else if (snooze_evt && (snooze_cnt_q < SNZ_MAX)) begin
            state_d      = SNOOZE;
            snooze_cnt_d = snooze_cnt_q + 4'd1;
            snz_cnt_d    = SNZ_LOAD;
            buzzer_d     = 1'b0;
          end else if (bus.tick_1hz && (ring_cnt_q != 9'd0)) begin
            ring_cnt_d = ring_cnt_q - 9'd1;
            buzzer_d   = ~buzzer_q;
            if (ring_cnt_q == 9'd1) begin
              state_d  = IDLE;
              buzzer_d = 1'b0;
            end
          end
        end

        SNOOZE: begin
          if (stop_evt) begin
            state_d  = IDLE;
            buzzer_d = 1'b0;
          end else if (bus.tick_1hz && (snz_cnt_q != 9'd0)) begin
            snz_cnt_d = snz_cnt_q - 9'd1;
            if (snz_cnt_q == 9'd1) begin
              state_d    = RINGING;
              ring_cnt_d = RING_LOAD;
              buzzer_d   = 1'b1;
            end
          end
        end

        default: begin
          state_d  = IDLE;
          buzzer_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ring_cnt_q   <= 9'd0;
      snz_cnt_q    <= 9'd0;
      buzzer_q     <= 1'b0;
      snooze_cnt_q <= 4'd0;
    end else begin
      state_q      <= state_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      buzzer_q     <= buzzer_d;
      snooze_cnt_q <= snooze_cnt_d;
    end
  end

  assign bus.buzzer     = buzzer_q;
  assign bus.ringing    = (state_q == RINGING);
  assign bus.snoozing   = (state_q == SNOOZE);
  assign bus.snooze_cnt = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl: directed scenarios followed by random stimulus, every cycle
// compared against a behavioural model driven by the sampled button history.
module tb_alarm_ctrl;
  localparam int RS = 4;
  localparam int SS = 3;
  localparam int MS = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_ctrl_if bus ();

  alarm_ctrl #(.RING_SECS(RS), .SNOOZE_SECS(SS), .MAX_SNOOZE(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Model: mode 0 = idle, 1 = ringing, 2 = snoozing.
  int       m_mode, m_ring, m_snz, m_used;
  bit       m_buz;
  bit [3:0] stop_h, snz_h;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit se, ze, mt;
    // A press acts three edges after it is first sampled low following a high sample.
    se = !stop_h[2] && stop_h[3];
    ze = !snz_h[2]  && snz_h[3];
    stop_h = {stop_h[2:0], bit'(bus.push_stop)};
    snz_h  = {snz_h[2:0],  bit'(bus.push_snooze)};
    mt = bus.tick_1hz && ({bus.ch1, bus.ch0, bus.cm1, bus.cm0} == {bus.ah1, bus.ah0, bus.am1, bus.am0})
         && ({bus.cs1, bus.cs0} == 8'h00);
    if (reset) begin
      stop_h = 4'hF; snz_h = 4'hF;
      m_mode = 0; m_ring = 0; m_snz = 0; m_used = 0; m_buz = 0;
    end else if (!bus.alarm_en) begin
      m_mode = 0; m_buz = 0;
    end else if (m_mode == 0) begin
      if (mt) begin m_mode = 1; m_ring = RS; m_buz = 1; m_used = 0; end
    end else if (se) begin
      m_mode = 0; m_buz = 0;
    end else if (m_mode == 1 && ze && m_used < MS) begin
      m_mode = 2; m_used++; m_snz = SS; m_buz = 0;
    end else if (bus.tick_1hz) begin
      if (m_mode == 1) begin
        m_ring--; m_buz = !m_buz;
        if (m_ring == 0) begin m_mode = 0; m_buz = 0; end
      end else begin
        m_snz--;
        if (m_snz == 0) begin m_mode = 1; m_ring = RS; m_buz = 1; end
      end
    end
  endtask

  task automatic step(input bit t);
    bus.tick_1hz = t;
    @(posedge clk);
    model_edge();
    #1;
    chk("ringing",    9'(bus.ringing),    9'(m_mode == 1));
    chk("snoozing",   9'(bus.snoozing),   9'(m_mode == 2));
    chk("buzzer",     9'(bus.buzzer),     9'(m_buz));
    chk("snooze_cnt", 9'(bus.snooze_cnt), 9'(m_used));
    bus.tick_1hz = 1'b0;
  endtask

  task automatic set_time(input int h1, h0, m1, m0, s1, s0);
    bus.ch1 = 4'(h1); bus.ch0 = 4'(h0); bus.cm1 = 4'(m1);
    bus.cm0 = 4'(m0); bus.cs1 = 4'(s1); bus.cs0 = 4'(s0);
  endtask

  task automatic press(input bit do_stop, input bit do_snz);
    if (do_stop) bus.push_stop = 1'b0;
    if (do_snz)  bus.push_snooze = 1'b0;
    step(0); step(0);
    bus.push_stop = 1'b1; bus.push_snooze = 1'b1;
    step(0); step(0); step(0);
  endtask

  task automatic trigger();
    set_time(0, 7, 3, 0, 0, 0);
    step(1);
    set_time(0, 7, 3, 0, 0, 1);
  endtask

  int stop_hold, snz_hold, sel;

  initial begin
    reset = 1'b1;
    bus.tick_1hz = 1'b0; bus.alarm_en = 1'b1;
    bus.push_stop = 1'b1; bus.push_snooze = 1'b1;
    bus.ah1 = 4'd0; bus.ah0 = 4'd7; bus.am1 = 4'd3; bus.am0 = 4'd0;
    set_time(0, 0, 0, 0, 0, 0);
    step(0); step(0);
    reset = 1'b0;
    step(0);
    chk("rst_ring", 9'(bus.ringing), 9'd0);
    chk("rst_buz",  9'(bus.buzzer),  9'd0);
    chk("rst_snz",  9'(bus.snoozing), 9'd0);
    chk("rst_cnt",  9'(bus.snooze_cnt), 9'd0);

    // Trigger at 07:30:00 and ring out the timeout.
    set_time(0, 7, 2, 9, 5, 9); step(1);
    chk("t1_pre", 9'(bus.ringing), 9'd0);
    trigger();
    chk("t1_ring", 9'(bus.ringing), 9'd1);
    chk("t1_buz",  9'(bus.buzzer),  9'd1);
    step(0); step(1); chk("t2_buz1", 9'(bus.buzzer), 9'd0);
    step(1);          chk("t2_buz2", 9'(bus.buzzer), 9'd1);
    step(1);          chk("t2_buz3", 9'(bus.buzzer), 9'd0);
    step(1);          chk("t2_idle", 9'(bus.ringing), 9'd0);
    chk("t2_off", 9'(bus.buzzer), 9'd0);

    // Snooze, wait it out, and use up the snooze allowance.
    trigger();
    bus.push_snooze = 1'b0;
    step(0); step(0); step(0);
    chk("t3_early", 9'(bus.snoozing), 9'd0);
    step(0);
    bus.push_snooze = 1'b1;
    chk("t3_snz", 9'(bus.snoozing), 9'd1);
    chk("t3_cnt", 9'(bus.snooze_cnt), 9'd1);
    step(1); step(1); chk("t3_wait", 9'(bus.snoozing), 9'd1);
    step(1); chk("t3_resume", 9'(bus.ringing), 9'd1);
    chk("t3_rbuz", 9'(bus.buzzer), 9'd1);
    press(0, 1); chk("t4_cnt2", 9'(bus.snooze_cnt), 9'd2);
    step(1); step(1); step(1);
    press(0, 1);
    chk("t4_ign", 9'(bus.ringing), 9'd1);
    chk("t4_cnt", 9'(bus.snooze_cnt), 9'd2);

    // Stop beats snooze; disabling the alarm forces idle.
    press(1, 1);
    chk("t5_idle", 9'(bus.ringing), 9'd0);
    chk("t5_cnt",  9'(bus.snooze_cnt), 9'd2);
    trigger(); press(0, 1);
    chk("t5_snz", 9'(bus.snoozing), 9'd1);
    bus.alarm_en = 1'b0; step(0);
    chk("t5_en", 9'(bus.snoozing), 9'd0);
    bus.alarm_en = 1'b1;

    // Reset mid-ring, then no ringing until the next match.
    trigger(); step(0);
    reset = 1'b1; step(0); reset = 1'b0;
    chk("t6_ring", 9'(bus.ringing), 9'd0);
    chk("t6_buz",  9'(bus.buzzer), 9'd0);
    step(1); step(1);
    chk("t6_noretrig", 9'(bus.ringing), 9'd0);
    trigger();
    chk("t6_retrig", 9'(bus.ringing), 9'd1);

    // Random phase.
    stop_hold = 0; snz_hold = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      bus.alarm_en = ($urandom_range(0, 39) != 0);
      if ($urandom_range(0, 499) == 0) begin
        bus.ah1 = 4'($urandom_range(0, 2)); bus.ah0 = 4'($urandom_range(0, 9));
        bus.am1 = 4'($urandom_range(0, 5)); bus.am0 = 4'($urandom_range(0, 9));
      end
      if (stop_hold > 0) stop_hold--;
      else if ($urandom_range(0, 24) == 0) stop_hold = $urandom_range(1, 4);
      if (snz_hold > 0) snz_hold--;
      else if ($urandom_range(0, 9) == 0) snz_hold = $urandom_range(1, 4);
      bus.push_stop   = (stop_hold == 0);
      bus.push_snooze = (snz_hold == 0);
      sel = $urandom_range(0, 7);
      case (sel)
        0: set_time(int'(bus.ah1), int'(bus.ah0), int'(bus.am1), int'(bus.am0), 0, 0);
        1: set_time(int'(bus.ah1), int'(bus.ah0), int'(bus.am1), int'(bus.am0), 0, 1);
        2: set_time(int'(bus.ah1), int'(bus.ah0), int'(bus.am1), int'(bus.am0 ^ 4'd1), 0, 0);
        default: set_time($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
      endcase
      step($urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
